ram_master: RTL and testbench

- Bus-side initiator for the 16-bit single-port RAM. It drives that RAM's three strobes (mar_load, ram_en, ram_load) and the shared 16-bit bus, and captures the RAM's registered read output.
- It accepts single or burst read/write requests over a valid/ready interface, with auto-incrementing address.
- It lets the control unit or a future DMA/loader access memory without hand-sequencing MAR loads.

---
 rtl/ram_master_pkg.sv | 18 +
 rtl/ram_master_if.sv | 37 +++
 rtl/ram_master.sv | 121 ++++++++++++
 tb/tb_ram_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_master_pkg.sv
// Shared widths and FSM state encoding for the RAM bus master.
package ram_master_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_RD_EN   = 3'd2,
        ST_RD_CAP  = 3'd3,
        ST_RSP     = 3'd4,
        ST_WR_WAIT = 3'd5,
        ST_WR      = 3'd6
    } state_e;

endpackage

// File: rtl/ram_master_if.sv
// Request/write-data/response handshakes plus the RAM strobe and shared-bus signals.
interface ram_master_if;
    import ram_master_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              done;
    logic              mar_load;
    logic              ram_en;
    logic              ram_load;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic [DATA_W-1:0] ram_out;

    modport master (
        input  req_valid, req_we, req_addr, req_len, wd_valid, wd_data, rsp_ready, ram_out,
        output req_ready, wd_ready, rsp_valid, rsp_data, rsp_last, done,
               mar_load, ram_en, ram_load, bus_out, bus_oe
    );

    modport slave (
        output req_valid, req_we, req_addr, req_len, wd_valid, wd_data, rsp_ready, ram_out,
        input  req_ready, wd_ready, rsp_valid, rsp_data, rsp_last, done,
               mar_load, ram_en, ram_load, bus_out, bus_oe
    );

endinterface

// File: rtl/ram_master.sv
// Burst read/write initiator for the single-port RAM: sequences MAR load, read and write
// strobes per beat with an auto-incrementing address.
module ram_master
    import ram_master_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    ram_master_if.master rm
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              last_c;

    logic              req_ready_q, wd_ready_q, rsp_valid_q, rsp_last_q, done_q;
    logic              mar_load_q, ram_en_q, ram_load_q, bus_oe_q;
    logic [DATA_W-1:0] bus_out_q, rsp_data_q;

    assign last_c = (cnt_q == '0);

    // Next-state and beat bookkeeping
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (rm.req_valid) begin
                    addr_d  = rm.req_addr;
                    cnt_d   = rm.req_len;
                    we_d    = rm.req_we;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (we_q) state_d = ST_WR_WAIT;
                else      state_d = ST_RD_EN;
            end
            ST_RD_EN:  state_d = ST_RD_CAP;
            ST_RD_CAP: state_d = ST_RSP;
            ST_WR_WAIT: begin
                if (rm.wd_valid) begin
                    wdata_d = rm.wd_data;
                    state_d = ST_WR;
                end
            end
            ST_RSP, ST_WR: begin
                if (state_q == ST_WR || rm.rsp_ready) begin
                    if (last_c) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = ADDR_W'(addr_q + 1'b1);
                        cnt_d   = LEN_W'(cnt_q - 1'b1);
                        state_d = ST_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered as a decode of the upcoming state, so they track state_q exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            wd_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            done_q      <= 1'b0;
            mar_load_q  <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_load_q  <= 1'b0;
            bus_oe_q    <= 1'b0;
            bus_out_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            req_ready_q <= (state_d == ST_IDLE);
            wd_ready_q  <= (state_d == ST_WR_WAIT);
            rsp_valid_q <= (state_d == ST_RSP);
            rsp_last_q  <= (state_d == ST_RSP) && (cnt_d == '0);
            done_q      <= (state_d == ST_IDLE) && (state_q != ST_IDLE);
            mar_load_q  <= (state_d == ST_ADDR);
            ram_en_q    <= (state_d == ST_RD_EN);
            ram_load_q  <= (state_d == ST_WR);
            bus_oe_q    <= (state_d == ST_ADDR) || (state_d == ST_WR);
            if (state_d == ST_ADDR)    bus_out_q <= DATA_W'(addr_d);
            else if (state_d == ST_WR) bus_out_q <= wdata_d;
            else                       bus_out_q <= '0;
            // RAM output became valid at the ram_en edge; sample it one cycle later
            if (state_q == ST_RD_CAP)  rsp_data_q <= rm.ram_out;
        end
    end

    assign rm.req_ready = req_ready_q;
    assign rm.wd_ready  = wd_ready_q;
    assign rm.rsp_valid = rsp_valid_q;
    assign rm.rsp_last  = rsp_last_q;
    assign rm.rsp_data  = rsp_data_q;
    assign rm.done      = done_q;
    assign rm.mar_load  = mar_load_q;
    assign rm.ram_en    = ram_en_q;
    assign rm.ram_load  = ram_load_q;
    assign rm.bus_oe    = bus_oe_q;
    assign rm.bus_out   = bus_out_q;

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master: behavioural RAM, shadow-memory reference and
// directed plus randomized bursts.
module tb_ram_master;
    import ram_master_pkg::*;

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] shadow [DEPTH];
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] mar_seen [$];

    ram_master_if bus ();

    ram_master dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rm    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_val(input int a);
        return DATA_W'(a * 40503 + 17);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural single-port RAM with strobe priority mar_load > ram_load > ram_en
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = init_val(i);
        mar         = '0;
        bus.ram_out = '0;
        forever begin
            @(posedge clk);
            if (bus.mar_load)      mar         <= bus.bus_out[ADDR_W-1:0];
            else if (bus.ram_load) mem[mar]    <= bus.bus_out;
            else if (bus.ram_en)   bus.ram_out <= mem[mar];
        end
    end

    // Per-cycle protocol invariants and MAR address capture
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("strobe_excl",
                32'($countones({bus.mar_load, bus.ram_en, bus.ram_load}) <= 1), 32'd1);
            chk("bus_oe", 32'(bus.bus_oe), 32'(bus.mar_load | bus.ram_load));
            if (bus.wd_ready || bus.rsp_valid)
                chk("wait_no_strobe", 32'({bus.mar_load, bus.ram_en, bus.ram_load}), 32'd0);
            if (bus.mar_load) mar_seen.push_back(bus.bus_out[ADDR_W-1:0]);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
        int n;
        n = 0;
        mar_seen.delete();
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_len   = len;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        chk("req_accept", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = ADDR_W'($urandom);
        bus.req_len   = LEN_W'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.done && n < 20) begin @(negedge clk); n++; end
        chk(tag, 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd0);
    endtask

    task automatic check_mar(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
        logic [ADDR_W-1:0] ea;
        chk("mar_count", 32'(mar_seen.size()), 32'(len) + 32'd1);
        foreach (mar_seen[i]) begin
            ea = a + ADDR_W'(i);
            chk("mar_addr", 32'(mar_seen[i]), 32'(ea));
        end
    endtask

    task automatic read_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                              input int stall0, input int max_stall);
        logic [DATA_W-1:0] held;
        int n, st;
        issue(1'b0, a, len);
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
            if (i == 0) chk("rd_latency", 32'(n), 32'd3);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_data", 32'(bus.rsp_data), 32'(shadow[a + ADDR_W'(i)]));
            chk("rsp_last", 32'(bus.rsp_last), 32'(i == int'(len)));
            st   = (i == 0) ? stall0 : int'($urandom_range(max_stall, 0));
            held = bus.rsp_data;
            repeat (st) begin
                @(negedge clk);
                chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
                chk("hold_data", 32'(bus.rsp_data), 32'(held));
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
        end
        wait_done("rd_done");
        check_mar(a, len);
    endtask

    task automatic write_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                               input int gap, input logic [DATA_W-1:0] base, input bit rnd);
        logic [DATA_W-1:0] d;
        int n;
        issue(1'b1, a, len);
        for (int i = 0; i <= int'(len); i++) begin
            d = rnd ? DATA_W'($urandom) : DATA_W'(base + DATA_W'(i));
            bus.wd_valid = 1'b0;
            repeat (gap) @(negedge clk);
            bus.wd_valid = 1'b1;
            bus.wd_data  = d;
            n = 0;
            while (!bus.wd_ready && n < 20) begin @(negedge clk); n++; end
            chk("wd_ready", 32'(bus.wd_ready), 32'd1);
            @(negedge clk);
            bus.wd_valid = 1'b0;
            bus.wd_data  = DATA_W'($urandom);
            shadow[a + ADDR_W'(i)] = d;
        end
        wait_done("wr_done");
        check_mar(a, len);
        for (int i = 0; i <= int'(len); i++)
            chk("ram_word", 32'(mem[a + ADDR_W'(i)]), 32'(shadow[a + ADDR_W'(i)]));
    endtask

    logic [ADDR_W-1:0] ra;
    logic [LEN_W-1:0]  rl;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) shadow[i] = init_val(i);
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'({bus.mar_load, bus.ram_en, bus.ram_load, bus.bus_oe,
                                bus.rsp_valid, bus.rsp_last, bus.done, bus.wd_ready}), 32'd0);
        chk("rst_bus_out", 32'(bus.bus_out), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Cycle-exact single write with write data already valid
        mar_seen.delete();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 12'h00D;
        bus.req_len   = 8'd0;
        bus.wd_valid  = 1'b1;
        bus.wd_data   = 16'h0001;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("w1_mar_load", 32'({bus.mar_load, bus.bus_oe}), 32'd3);
        chk("w1_mar_bus", 32'(bus.bus_out), 32'h000D);
        @(negedge clk);
        chk("w1_wd_ready", 32'(bus.wd_ready), 32'd1);
        @(negedge clk);
        bus.wd_valid = 1'b0;
        chk("w1_ram_load", 32'({bus.ram_load, bus.bus_oe}), 32'd3);
        chk("w1_wr_bus", 32'(bus.bus_out), 32'h0001);
        @(negedge clk);
        chk("w1_done", 32'(bus.done), 32'd1);
        chk("w1_req_ready", 32'(bus.req_ready), 32'd1);
        shadow[13] = 16'h0001;
        @(negedge clk);
        chk("w1_ram13", 32'(mem[13]), 32'h0001);

        // Preload 14..15 = 1,2 then read three beats from 0x00D
        write_burst(12'h00E, 8'd1, 0, 16'h0001, 1'b0);
        read_burst(12'h00D, 8'd2, 0, 0);

        // Address wrap at the top of the address space
        write_burst(12'hFFF, 8'd1, 1, 16'h0, 1'b1);
        read_burst(12'hFFF, 8'd1, 0, 0);
        chk("wrap_mar", (mar_seen.size() == 2) ? 32'(mar_seen[1]) : 32'hFFFF_FFFF, 32'd0);

        // Consumer back-pressure on the first beat
        read_burst(12'h00D, 8'd2, 5, 1);

        // Gapped write data: A0..A3 at consecutive addresses
        write_burst(12'h100, 8'd3, 2, 16'h00A0, 1'b0);
        chk("gap_word3", 32'(mem[12'h103]), 32'h00A3);

        // Reset during the RD_EN cycle of a four-beat read
        issue(1'b0, 12'h200, 8'd3);
        @(negedge clk);
        chk("pre_rst_ram_en", 32'(bus.ram_en), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_strobes", 32'({bus.mar_load, bus.ram_en, bus.ram_load, bus.bus_oe}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
            chk("post_rst_quiet", 32'({bus.rsp_valid, bus.done}), 32'd0);
        end

        // Randomized bursts against the shadow memory
        for (int k = 0; k < 40; k++) begin
            ra = ($urandom_range(3, 0) == 0) ? ADDR_W'(32'hFFC + $urandom_range(3, 0))
                                             : ADDR_W'($urandom);
            rl = LEN_W'($urandom_range(7, 0));
            if ($urandom_range(1, 0) == 1)
                write_burst(ra, rl, int'($urandom_range(2, 0)), 16'h0, 1'b1);
            else
                read_burst(ra, rl, int'($urandom_range(2, 0)), 2);
        end

        // Maximum-length bursts crossing the wrap point
        write_burst(12'hF80, 8'd255, 0, 16'h0, 1'b1);
        read_burst(12'hF80, 8'd255, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
